// File: rtl/sc_ota_readout_ctrl.sv
// Read-side controller for the SC filter: bias enable and settle, non-overlapping
// phi1/phi2 generation, comparator strobing, per-frame ones count with valid/ready handoff.
module sc_ota_readout_ctrl #(
    parameter int SETTLE_CYC = 16,
    parameter int PHI_CYC    = 4,
    parameter int DEAD_CYC   = 1,
    parameter int NSAMP      = 8,
    parameter int CNT_W      = $clog2(NSAMP + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             bias_en,
    output logic             phi1,
    output logic             phi2,
    output logic             comp_latch,
    input  logic             comp_out,
    output logic [CNT_W-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy
);

    localparam int MAX_SP  = (SETTLE_CYC > PHI_CYC) ? SETTLE_CYC : PHI_CYC;
    localparam int MAX_CYC = (MAX_SP > DEAD_CYC) ? MAX_SP : DEAD_CYC;
    localparam int PH_W    = $clog2(MAX_CYC + 1);

    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
    localparam logic [PH_W-1:0]  PHI_LAST    = PH_W'(PHI_CYC - 1);
    localparam logic [PH_W-1:0]  DEAD_LAST   = PH_W'(DEAD_CYC - 1);
    localparam logic [PH_W-1:0]  PH_ONE      = PH_W'(1);
    localparam logic [CNT_W-1:0] NSAMP_C     = CNT_W'(NSAMP);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_PHI1,
        S_DEAD1,
        S_PHI2,
        S_DEAD2,
        S_OUT
    } state_t;

    state_t           state, state_nxt;
    logic [PH_W-1:0]  phase_cnt, phase_nxt;
    logic [CNT_W-1:0] samp_cnt, samp_nxt;
    logic [CNT_W-1:0] ones_cnt, ones_nxt;
    logic [CNT_W-1:0] dout_nxt;
    logic             dv_nxt;
    logic             abort;

    always_comb begin
        state_nxt = state;
        phase_nxt = phase_cnt;
        samp_nxt  = samp_cnt;
        ones_nxt  = ones_cnt;
        dout_nxt  = data_out;
        dv_nxt    = data_valid;
        abort     = !en && (state != S_IDLE) && (state != S_OUT);

        case (state)
            S_IDLE: begin
                if (en) begin
                    state_nxt = S_SETTLE;
                    phase_nxt = '0;
                end
            end
            S_SETTLE: begin
                if (phase_cnt == SETTLE_LAST) begin
                    state_nxt = S_PHI1;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + PH_ONE;
                end
            end
            S_PHI1: begin
                if (phase_cnt == PHI_LAST) begin
                    state_nxt = S_DEAD1;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + PH_ONE;
                end
            end
            S_DEAD1: begin
                if (phase_cnt == DEAD_LAST) begin
                    state_nxt = S_PHI2;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + PH_ONE;
                end
            end
            S_PHI2: begin
                if (phase_cnt == PHI_LAST) begin
                    state_nxt = S_DEAD2;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + PH_ONE;
                end
            end
            S_DEAD2: begin
                // The decision latched at the end of PHI2 is taken in the first dead cycle
                if (phase_cnt == '0) begin
                    samp_nxt = samp_cnt + CNT_ONE;
                    if (comp_out && (ones_cnt < NSAMP_C))
                        ones_nxt = ones_cnt + CNT_ONE;
                end
                if (phase_cnt == DEAD_LAST) begin
                    phase_nxt = '0;
                    if (samp_nxt < NSAMP_C) begin
                        state_nxt = S_PHI1;
                    end else begin
                        state_nxt = S_OUT;
                        dout_nxt  = ones_nxt;
                        dv_nxt    = 1'b1;
                        samp_nxt  = '0;
                        ones_nxt  = '0;
                    end
                end else begin
                    phase_nxt = phase_cnt + PH_ONE;
                end
            end
            S_OUT: begin
                // Filter is held (both phases low) until the consumer takes the count
                if (data_ready) begin
                    dv_nxt    = 1'b0;
                    phase_nxt = '0;
                    state_nxt = en ? S_PHI1 : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                phase_nxt = '0;
                samp_nxt  = '0;
                ones_nxt  = '0;
                dv_nxt    = 1'b0;
            end
        endcase

        if (abort) begin
            state_nxt = S_IDLE;
            phase_nxt = '0;
            samp_nxt  = '0;
            ones_nxt  = '0;
            dout_nxt  = '0;
            dv_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            phase_cnt  <= '0;
            samp_cnt   <= '0;
            ones_cnt   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            bias_en    <= 1'b0;
            busy       <= 1'b0;
            phi1       <= 1'b0;
            phi2       <= 1'b0;
            comp_latch <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase_cnt  <= phase_nxt;
            samp_cnt   <= samp_nxt;
            ones_cnt   <= ones_nxt;
            data_out   <= dout_nxt;
            data_valid <= dv_nxt;
            // Outputs are registered decodes of the next state so they mirror the state flop
            bias_en    <= (state_nxt != S_IDLE);
            busy       <= (state_nxt != S_IDLE);
            phi1       <= (state_nxt == S_PHI1);
            phi2       <= (state_nxt == S_PHI2);
            comp_latch <= (state_nxt == S_PHI2) && (phase_nxt == PHI_LAST);
        end
    end

endmodule

// File: tb/tb_sc_ota_readout_ctrl.sv
// Directed bench for sc_ota_readout_ctrl with default parameters.
module tb_sc_ota_readout_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       bias_en;
    logic       phi1;
    logic       phi2;
    logic       comp_latch;
    logic       comp_out;
    logic [3:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    // event tracking, updated once per cycle by step()
    int cyc;
    int first_phi1, first_phi2, first_cl, first_dv, p1_len, dv_cnt, last_dout;
    logic dv_prev;
    logic alt_mode, alt_val;

    sc_ota_readout_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en(en), .bias_en(bias_en), .phi1(phi1), .phi2(phi2),
        .comp_latch(comp_latch), .comp_out(comp_out), .data_out(data_out),
        .data_valid(data_valid), .data_ready(data_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_track();
        first_phi1 = -1; first_phi2 = -1; first_cl = -1; first_dv = -1;
        p1_len = 0; dv_cnt = 0; last_dout = -1;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (phi1 && first_phi1 < 0) first_phi1 = cyc;
        if (phi1 && first_phi2 < 0) p1_len++;
        if (phi2 && first_phi2 < 0) first_phi2 = cyc;
        if (comp_latch && first_cl < 0) first_cl = cyc;
        if (data_valid && !dv_prev) begin
            dv_cnt++;
            last_dout = int'(data_out);
            if (first_dv < 0) first_dv = cyc;
        end
        dv_prev = data_valid;
        if (alt_mode && comp_latch) begin
            comp_out = alt_val;
            alt_val  = ~alt_val;
        end
    endtask

    // Phase overlap and non-overlap gap watch
    logic p1_q = 1'b0, p2_q = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("no_overlap", {31'd0, phi1 & phi2}, 32'd0);
            chk("dead_gap", {31'd0, (p1_q & phi2) | (p2_q & phi1)}, 32'd0);
        end
        p1_q <= phi1;
        p2_q <= phi2;
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; comp_out = 1'b1; data_ready = 1'b1;
        alt_mode = 1'b0; alt_val = 1'b1; dv_prev = 1'b0; cyc = 0;
        clr_track();
        #12;
        chk("rst_bias_en", {31'd0, bias_en}, 0);
        chk("rst_phi1", {31'd0, phi1}, 0);
        chk("rst_phi2", {31'd0, phi2}, 0);
        chk("rst_comp_latch", {31'd0, comp_latch}, 0);
        chk("rst_data_valid", {31'd0, data_valid}, 0);
        chk("rst_data_out", {28'd0, data_out}, 0);
        chk("rst_busy", {31'd0, busy}, 0);

        // Startup: en rises in cycle 0, comparator tied high
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cyc = 0; clr_track(); en = 1'b1;
        step();
        chk("start_bias_c1", {31'd0, bias_en}, 1);
        chk("start_busy_c1", {31'd0, busy}, 1);
        repeat (96) step();
        chk("first_phi1", first_phi1, 17);
        chk("phi1_len", p1_len, 4);
        chk("first_phi2", first_phi2, 22);
        chk("first_comp_latch", first_cl, 25);
        chk("first_dv", first_dv, 97);
        chk("ones_all1", last_dout, 8);
        chk("dv_pulses_f1", dv_cnt, 1);
        clr_track();
        repeat (81) step();
        chk("dv_pulses_f2", dv_cnt, 1);
        chk("ones_all1_f2", last_dout, 8);

        // Alternating decisions 1,0,1,0...
        alt_mode = 1'b1; alt_val = 1'b1;
        clr_track();
        repeat (81) step();
        chk("dv_pulses_alt", dv_cnt, 1);
        chk("ones_alt", last_dout, 4);

        // Comparator tied low
        alt_mode = 1'b0; comp_out = 1'b0;
        clr_track();
        repeat (81) step();
        chk("dv_pulses_zero", dv_cnt, 1);
        chk("ones_zero", last_dout, 0);

        // Backpressure: hold data_ready low for 5 cycles of data_valid
        comp_out = 1'b1;
        repeat (80) step();
        data_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_dv", {31'd0, data_valid}, 1);
            chk("hold_dout", {28'd0, data_out}, 8);
            chk("hold_phi1", {31'd0, phi1}, 0);
            chk("hold_phi2", {31'd0, phi2}, 0);
        end
        data_ready = 1'b1;
        step();
        chk("xfer_dv_drop", {31'd0, data_valid}, 0);
        chk("xfer_phi1_next", {31'd0, phi1}, 1);

        // Abort in the middle of PHI2
        repeat (6) step();
        chk("pre_abort_phi2", {31'd0, phi2}, 1);
        en = 1'b0;
        step();
        chk("abort_phi2", {31'd0, phi2}, 0);
        chk("abort_bias", {31'd0, bias_en}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        clr_track();
        repeat (100) step();
        chk("abort_no_dv", dv_cnt, 0);
        chk("abort_no_phi1", first_phi1, -1);

        // Re-enable: full settle again
        cyc = 0; clr_track(); en = 1'b1;
        repeat (20) step();
        chk("reen_first_phi1", first_phi1, 17);

        // Asynchronous reset mid-frame
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mid_bias", {31'd0, bias_en}, 0);
        chk("arst_mid_phi1", {31'd0, phi1}, 0);
        chk("arst_mid_busy", {31'd0, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1; dv_prev = 1'b0;
        cyc = 0; clr_track();
        alt_mode = 1'b1; alt_val = 1'b1; data_ready = 1'b0;
        repeat (97) step();
        chk("post_rst_first_dv", first_dv, 97);
        chk("post_rst_ones_alt", last_dout, 4);
        chk("out_wait_dv", {31'd0, data_valid}, 1);

        // Asynchronous reset while waiting in OUT: pending result discarded
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_dv", {31'd0, data_valid}, 0);
        chk("arst_out_dout", {28'd0, data_out}, 0);
        chk("arst_out_busy", {31'd0, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1; dv_prev = 1'b0;
        alt_mode = 1'b0; comp_out = 1'b1; data_ready = 1'b1;
        cyc = 0; clr_track();
        repeat (97) step();
        chk("fresh_first_dv", first_dv, 97);
        chk("fresh_ones", last_dout, 8);
        chk("fresh_dv_pulses", dv_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
